branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor for the RV32i pipeline: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. Each cycle it predicts direction and target for the current fetch PC so the PC mux can redirect without waiting for Execute. It learns from branches and JALs resolved in Execute. Execute remains authoritative for mispredict recovery.

## Interface
Parameters:
- BTB_ENTRIES, 16, number of entries; power of two, ≥ 2; IDX_W = log2(BTB_ENTRIES).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  reset. One clock; reset is synchronous and active-low.
- IF_PC  input  32  current fetch PC.
- Predict_Taken  output  1  PREDICT_TAKEN / PREDICT_NOT_TAKEN for IF_PC.
- Predict_Target  output  32  predicted target; 32'h0 whenever Predict_Taken = 0.
- EX_Update_En  input  1  a valid, unflushed B-type or JAL is resolved in Execute this cycle.
- EX_PC  input  32  PC of the resolved instruction.
- EX_Is_Jump  input  1  1 = JAL, 0 = conditional branch.
- Branch_Taken  input  1  BRANCH_TAKEN / BRANCH_NOT_TAKEN resolved outcome.
- EX_Target  input  32  resolved target address.
- EX_Mispredict  input  1  Execute flagged a mispredict; used only for statistics.
- Stat_Branches  output  32  resolved-update count (BP_STATS_EN only).
- Stat_Mispredicts  output  32  mispredict count (BP_STATS_EN only).

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]; PC[1:0] is ignored.
- Entry fields: valid, tag, target[31:0], state[1:0] (Branch_State encoding).
- Lookup (combinational): hit = valid & tag match. Predict_Taken = hit & state[1]. Predict_Target = the entry target when Predict_Taken = 1, else 0.
- Update when EX_Update_En = 1 (indexed by EX_PC):
  - Hit, conditional branch: saturating step. Taken increments up to STRONGLY_TAKEN; not-taken decrements down to STRONGLY_UNTAKEN. When taken, target is overwritten with EX_Target.
  - Hit, JAL: state ← STRONGLY_TAKEN, target ← EX_Target.
  - Miss, taken: allocate. Valid ← 1, tag and target written. State ← WEAKLY_TAKEN for branches, STRONGLY_TAKEN for JAL. Any existing entry is replaced.
  - Miss, not taken: no change.
- JALR is never presented; Execute keeps EX_Update_En low for it.
- With EX_Update_En = 0, no state changes.

## Timing
- Lookup latency: 0 cycles, combinational from IF_PC.
- Update latency: 1 cycle. The written entry becomes visible to lookup on the cycle after the EX_Update_En edge.
- Same-index lookup and update in one cycle: lookup returns the pre-update contents. There is no bypass.
- Reset (RST_N low at a rising edge): all valid ← 0, all state ← WEAKLY_UNTAKEN, targets and tags ← 0, stat counters ← 0.
  - An update presented in the same cycle as reset is discarded.
  - Reset applied mid-run takes precedence over everything.
- Output values after reset: Predict_Taken = 0, Predict_Target = 0, Stat_* = 0.
- Tag aliasing is not possible; every distinct PC maps to a unique index/tag pair.

## Configuration
- BP_STATS_EN defined:
  - Stat_Branches increments on every EX_Update_En cycle.
  - Stat_Mispredicts increments when EX_Update_En & EX_Mispredict.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF; they do not wrap.
- BP_STATS_EN undefined: both counters are removed and the Stat_* ports are tied to 0. Prediction behaviour is identical either way.

## Structure
- Add to the definitions package:
  - BTB_ENTRIES default.
  - btb_entry_t packed struct: valid, tag, target, state.
  - BP_ALLOC_BRANCH = WEAKLY_TAKEN and BP_ALLOC_JUMP = STRONGLY_TAKEN.
- Reuse the existing Branch_State, Branch_Taken and Predict_Taken constants.
- One sub-module, sat_counter_2b: a combinational next-state function taking current state and taken, producing the saturated state. It can be reused by any later predictor.

## Test plan
- Reset, then IF_PC = 0x100 → Predict_Taken = 0, Predict_Target = 0; Stat_* = 0.
- Taken branch update at EX_PC = 0x100, EX_Target = 0x80 → next cycle IF_PC = 0x100 gives Predict_Taken = 1, Predict_Target = 0x80 (state WEAKLY_TAKEN).
- Same entry: one not-taken update → Predict_Taken = 0. Three more not-taken → state STRONGLY_UNTAKEN. One taken → still not predicted. A second taken → predicted.
- Aliasing with BTB_ENTRIES = 16: allocate at 0x100, then taken at 0x140 → 0x100 misses (Predict_Taken = 0) and 0x140 hits. A not-taken miss at 0x180 leaves the 0x140 entry intact.
- Simultaneous update and lookup on 0x200 at allocation → Predict_Taken = 0 that cycle and 1 the next. Update with RST_N low → entry not allocated.
- With BP_STATS_EN: 5 updates, 2 with EX_Mispredict → Stat_Branches = 5, Stat_Mispredicts = 2. Preload to 32'hFFFF_FFFF, one more update → counter holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: direction/outcome
// encodings, BTB entry layout and allocation policy.
package branch_predictor_pkg;

  localparam int BP_BTB_ENTRIES = 16;

  // Widest tag any legal BTB_ENTRIES (>= 2) can need: 32 - 2 - 1 bits.
  localparam int BP_TAG_MAX_W = 29;

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } branch_state_e;

  typedef enum logic {
    BRANCH_NOT_TAKEN = 1'b0,
    BRANCH_TAKEN     = 1'b1
  } branch_taken_e;

  typedef enum logic {
    PREDICT_NOT_TAKEN = 1'b0,
    PREDICT_TAKEN     = 1'b1
  } predict_taken_e;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
    branch_state_e           state;
  } btb_entry_t;

  localparam branch_state_e BP_ALLOC_BRANCH = WEAKLY_TAKEN;
  localparam branch_state_e BP_ALLOC_JUMP   = STRONGLY_TAKEN;

endpackage

// File: rtl/branch_predictor_sat_counter_2b.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module sat_counter_2b
  import branch_predictor_pkg::*;
(
  input  branch_state_e state,
  input  logic          taken,
  output branch_state_e next_state
);

  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      STRONGLY_UNTAKEN: next_state = taken ? WEAKLY_UNTAKEN : STRONGLY_UNTAKEN;
      WEAKLY_UNTAKEN:   next_state = taken ? WEAKLY_TAKEN   : STRONGLY_UNTAKEN;
      WEAKLY_TAKEN:     next_state = taken ? STRONGLY_TAKEN : WEAKLY_UNTAKEN;
      STRONGLY_TAKEN:   next_state = taken ? STRONGLY_TAKEN : WEAKLY_TAKEN;
      default:          next_state = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; predicts for IF_PC, learns
// from Execute. Optional statistics counters enabled by `define BP_STATS_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = BP_BTB_ENTRIES
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IF_PC,
  output logic        Predict_Taken,
  output logic [31:0] Predict_Target,
  input  logic        EX_Update_En,
  input  logic [31:0] EX_PC,
  input  logic        EX_Is_Jump,
  input  logic        Branch_Taken,
  input  logic [31:0] EX_Target,
  input  logic        EX_Mispredict,
  output logic [31:0] Stat_Branches,
  output logic [31:0] Stat_Mispredicts
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb_q [BTB_ENTRIES];

  // ---------------- Lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  btb_entry_t       if_entry;
  logic             if_hit;

  assign if_idx   = IF_PC[IDX_W+1:2];
  assign if_tag   = IF_PC[31:IDX_W+2];
  assign if_entry = btb_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == BP_TAG_MAX_W'(if_tag));

  assign Predict_Taken  = if_hit && if_entry.state[1];
  assign Predict_Target = Predict_Taken ? if_entry.target : 32'h0;

  // ---------------- Update ----------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       ex_entry;
  logic             ex_hit;
  branch_state_e    ex_sat_state;
  btb_entry_t       upd_entry;
  logic             upd_we;

  assign ex_idx   = EX_PC[IDX_W+1:2];
  assign ex_tag   = EX_PC[31:IDX_W+2];
  assign ex_entry = btb_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == BP_TAG_MAX_W'(ex_tag));

  sat_counter_2b u_sat_counter (
    .state      (ex_entry.state),
    .taken      (Branch_Taken),
    .next_state (ex_sat_state)
  );

  always_comb begin
    upd_we    = 1'b0;
    upd_entry = ex_entry;
    if (EX_Update_En) begin
      if (ex_hit) begin
        upd_we = 1'b1;
        if (EX_Is_Jump) begin
          upd_entry.state  = STRONGLY_TAKEN;
          upd_entry.target = EX_Target;
        end else begin
          upd_entry.state = ex_sat_state;
          if (Branch_Taken == BRANCH_TAKEN) upd_entry.target = EX_Target;
        end
      end else if (Branch_Taken == BRANCH_TAKEN) begin
        // Miss on a taken instruction: evict whatever occupies the slot.
        upd_we           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = BP_TAG_MAX_W'(ex_tag);
        upd_entry.target = EX_Target;
        upd_entry.state  = EX_Is_Jump ? BP_ALLOC_JUMP : BP_ALLOC_BRANCH;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // NOTE: the whole table is cleared on reset (not just valid bits) so the
      // counters restart from WEAKLY_UNTAKEN and no stale target survives;
      // this forces flops rather than a RAM macro, acceptable at BTB sizes.
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, state: WEAKLY_UNTAKEN};
      end
    end else if (upd_we) begin
      // NOTE: non-blocking so lookups this cycle still see the old entry.
      btb_q[ex_idx] <= upd_entry;
    end
  end

  // ---------------- Statistics ----------------
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (EX_Update_En) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (EX_Mispredict && (stat_mispredicts_q != '1)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign Stat_Branches    = stat_branches_q;
  assign Stat_Mispredicts = stat_mispredicts_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};
`else
  assign Stat_Branches    = 32'h0;
  assign Stat_Mispredicts = 32'h0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0], EX_Mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ex_update_en;
  logic [31:0] ex_pc;
  logic        ex_is_jump;
  logic        branch_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(16)) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .IF_PC            (if_pc),
    .Predict_Taken    (predict_taken),
    .Predict_Target   (predict_target),
    .EX_Update_En     (ex_update_en),
    .EX_PC            (ex_pc),
    .EX_Is_Jump       (ex_is_jump),
    .Branch_Taken     (branch_taken),
    .EX_Target        (ex_target),
    .EX_Mispredict    (ex_mispredict),
    .Stat_Branches    (stat_branches),
    .Stat_Mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] branches;
    logic [31:0] mispredicts;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle well before the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".taken"},  {31'd0, predict_taken}, {31'd0, e.taken});
      check({e.name, ".target"}, predict_target,   e.target);
      check({e.name, ".stat_br"}, stat_branches,   e.branches);
      check({e.name, ".stat_mp"}, stat_mispredicts, e.mispredicts);
    end
  end

  task automatic step(input logic rst, input logic [31:0] pc, input logic upd,
                      input logic [31:0] epc, input logic jump, input logic tkn,
                      input logic [31:0] tgt, input logic mp, input logic chk,
                      input logic et, input logic [31:0] etgt, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rst;
    if_pc         = pc;
    ex_update_en  = upd;
    ex_pc         = epc;
    ex_is_jump    = jump;
    branch_taken  = tkn;
    ex_target     = tgt;
    ex_mispredict = mp;
    if (chk) begin
      e = '{taken: et, target: etgt, branches: exp_br, mispredicts: exp_mp, name: name};
      exp_q.push_back(e);
    end
`ifdef BP_STATS_EN
    if (!rst) begin
      exp_br = '0;
      exp_mp = '0;
    end else if (upd) begin
      exp_br = exp_br + 32'd1;
      if (mp) exp_mp = exp_mp + 32'd1;
    end
`endif
  endtask

  task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] etgt,
                      input string name);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, et, etgt, name);
  endtask

  task automatic br(input logic [31:0] epc, input logic tkn, input logic [31:0] tgt,
                    input logic mp);
    step(1'b1, 32'h0, 1'b1, epc, 1'b0, tkn, tgt, mp, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic jal(input logic [31:0] epc, input logic [31:0] tgt);
    step(1'b1, 32'h0, 1'b1, epc, 1'b1, 1'b1, tgt, 1'b0, 1'b0, 1'b0, 32'h0, "");
  endtask

  initial begin
    rst_n = 1'b0; if_pc = '0; ex_update_en = 1'b0; ex_pc = '0;
    ex_is_jump = 1'b0; branch_taken = 1'b0; ex_target = '0; ex_mispredict = 1'b0;

    // Reset with a taken update presented: the update must be dropped.
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0, "");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "");
    look(32'h100, 1'b0, 32'h0, "reset_0x100");
    look(32'h200, 1'b0, 32'h0, "rst_upd_discarded");

    // Allocation: lookup in the allocating cycle still misses.
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, "alloc_same_cycle");
    look(32'h100, 1'b1, 32'h80, "alloc_wt");

    // Counter walk down, saturate, then retrain.
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80, "nt_pre_update");
    look(32'h100, 1'b0, 32'h0, "wu_after_nt");
    br(32'h100, 1'b0, 32'h0, 1'b0);
    br(32'h100, 1'b0, 32'h0, 1'b0);
    br(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b0, 32'h0, "su_saturated");
    br(32'h100, 1'b1, 32'h84, 1'b1);
    look(32'h100, 1'b0, 32'h0, "su_plus_one");
    br(32'h100, 1'b1, 32'h88, 1'b1);
    look(32'h100, 1'b1, 32'h88, "retrained_wt");
    br(32'h100, 1'b1, 32'h88, 1'b0);
    br(32'h100, 1'b1, 32'h88, 1'b0);
    br(32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100, 1'b1, 32'h88, "st_saturated_then_nt");

    // Aliasing on index 0.
    br(32'h140, 1'b1, 32'h300, 1'b1);
    look(32'h100, 1'b0, 32'h0, "alias_evicted");
    look(32'h140, 1'b1, 32'h300, "alias_alloc");
    br(32'h180, 1'b0, 32'h777, 1'b0);
    look(32'h140, 1'b1, 32'h300, "nt_miss_no_alloc");

    // JAL on a hit goes strongly taken; JAL allocation starts strongly taken.
    jal(32'h140, 32'h310);
    br(32'h140, 1'b0, 32'h0, 1'b0);
    look(32'h140, 1'b1, 32'h310, "jal_hit_st");
    jal(32'h204, 32'h400);
    br(32'h204, 1'b0, 32'h0, 1'b0);
    look(32'h204, 1'b1, 32'h400, "jal_alloc_st");
    br(32'h204, 1'b0, 32'h0, 1'b0);
    look(32'h204, 1'b0, 32'h0, "jal_entry_wu");

    // Same-cycle lookup/update: no bypass.
    step(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0, "no_bypass");
    look(32'h200, 1'b1, 32'h500, "visible_next");
    look(32'h203, 1'b1, 32'h500, "pc_low_bits_ignored");
    look(32'h140, 1'b0, 32'h0, "replaced_by_0x200");

    // Update enable low: nothing changes.
    step(1'b1, 32'h200, 1'b0, 32'h200, 1'b1, 1'b1, 32'h999, 1'b1, 1'b1, 1'b1, 32'h500, "en_low_pre");
    look(32'h200, 1'b1, 32'h500, "en_low_no_change");

    // Mid-run reset clears everything.
    step(1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h500, "pre_reset");
    look(32'h200, 1'b0, 32'h0, "mid_reset_0x200");
    look(32'h204, 1'b0, 32'h0, "mid_reset_0x204");

    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
